// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing generator: pixel enable, beam position, blank/sync strobes
// NTSC/PAL line counts with optional scan-doubling; all outputs registered.
module video_timing #(
   parameter int CLK_DIV    = 4,
   parameter int H_ACTIVE   = 320,
   parameter int H_TOTAL    = 384,
   parameter int HS_START   = 336,
   parameter int HS_END     = 368,
   parameter int V_ACTIVE   = 240,
   parameter int NTSC_LINES = 262,
   parameter int PAL_LINES  = 312,
   parameter int VS_START_N = 244,
   parameter int VS_START_P = 270,
   parameter int VS_LEN     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pal,
   input  logic       scandouble,
   output logic       ce_pix,
   output logic [8:0] hcount,
   output logic [8:0] vcount,
   output logic       HBlank,
   output logic       VBlank,
   output logic       HSync,
   output logic       VSync,
   output logic       new_line,
   output logic       new_frame
);

   localparam logic [7:0] DIV_FULL  = 8'(CLK_DIV - 1);
   localparam logic [7:0] DIV_HALF  = 8'(CLK_DIV / 2 - 1);
   localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
   localparam logic [8:0] H_ACT     = 9'(H_ACTIVE);
   localparam logic [8:0] HS_BEGIN  = 9'(HS_START);
   localparam logic [8:0] HS_STOP   = 9'(HS_END);
   localparam logic [8:0] V_ACT     = 9'(V_ACTIVE);
   localparam logic [8:0] NTSC_LAST = 9'(NTSC_LINES - 1);
   localparam logic [8:0] PAL_LAST  = 9'(PAL_LINES - 1);
   localparam logic [8:0] VS_N      = 9'(VS_START_N);
   localparam logic [8:0] VS_P      = 9'(VS_START_P);
   localparam logic [8:0] VS_LINES  = 9'(VS_LEN);

   logic [7:0] div;
   logic       armed;
   logic       pal_l;
   logic       sd_l;
   logic       rep;

   logic       pal_eff;
   logic       sd_eff;
   logic       ce;
   logic       h_wrap;
   logic       v_step;
   logic       f_wrap;
   logic       rep_nx;
   logic       pal_nx;
   logic [8:0] lines_last;
   logic [8:0] h_nx;
   logic [8:0] v_nx;
   logic [8:0] vs_start;
   logic [8:0] vs_end;

   // Until the first edge after release the mode pins drive the timing directly,
   // which is equivalent to latching them at the moment reset drops.
   always_comb begin
      pal_eff    = armed ? pal_l : pal;
      sd_eff     = armed ? sd_l : scandouble;
      ce         = (div == (sd_eff ? DIV_HALF : DIV_FULL));
      h_wrap     = (hcount == H_LAST);
      lines_last = pal_eff ? PAL_LAST : NTSC_LAST;
      v_step     = h_wrap && (!sd_eff || rep);
      f_wrap     = v_step && (vcount == lines_last);
      h_nx       = h_wrap ? 9'd0 : hcount + 9'd1;
      v_nx       = vcount;
      if (f_wrap)
         v_nx = 9'd0;
      else if (v_step)
         v_nx = vcount + 9'd1;
      rep_nx     = rep;
      if (f_wrap)
         rep_nx = 1'b0;
      else if (h_wrap && sd_eff)
         rep_nx = ~rep;
      pal_nx     = f_wrap ? pal : pal_eff;
      vs_start   = pal_nx ? VS_P : VS_N;
      vs_end     = vs_start + VS_LINES;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed <= 1'b0;
         pal_l <= 1'b0;
         sd_l  <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (!armed || (ce && f_wrap)) begin
            pal_l <= pal;
            sd_l  <= scandouble;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div       <= 8'd0;
         rep       <= 1'b0;
         ce_pix    <= 1'b0;
         hcount    <= 9'd0;
         vcount    <= 9'd0;
         HBlank    <= 1'b0;
         VBlank    <= 1'b0;
         HSync     <= 1'b0;
         VSync     <= 1'b0;
         new_line  <= 1'b0;
         new_frame <= 1'b0;
      end else begin
         ce_pix    <= ce;
         new_line  <= 1'b0;
         new_frame <= 1'b0;
         if (ce) begin
            div       <= 8'd0;
            rep       <= rep_nx;
            hcount    <= h_nx;
            vcount    <= v_nx;
            // strobes follow the next position so they line up with hcount/vcount
            HBlank    <= (h_nx >= H_ACT);
            VBlank    <= (v_nx >= V_ACT);
            HSync     <= (h_nx >= HS_BEGIN) && (h_nx < HS_STOP);
            VSync     <= (v_nx >= vs_start) && (v_nx < vs_end);
            new_line  <= h_wrap;
            new_frame <= f_wrap;
         end else begin
            div <= div + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - self-checking bench for video_timing
// Reduced raster geometry keeps whole frames short; a pixel-index model feeds the scoreboard.
module tb_video_timing;

   localparam int CD  = 4;
   localparam int HA  = 16;
   localparam int HT  = 24;
   localparam int HSS = 18;
   localparam int HSE = 21;
   localparam int VA  = 10;
   localparam int NL  = 14;
   localparam int PL  = 17;
   localparam int VSN = 11;
   localparam int VSP = 12;
   localparam int VSL = 3;

   typedef struct packed {
      logic [8:0] h;
      logic [8:0] v;
      logic       hb;
      logic       vb;
      logic       hs;
      logic       vs;
      logic       nl;
      logic       nf;
   } exp_t;

   typedef struct {
      logic pal;
      logic sd;
      int   gap;
      int   frame;
      int   vsl;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       pal;
   logic       scandouble;
   logic       ce_pix;
   logic [8:0] hcount;
   logic [8:0] vcount;
   logic       HBlank;
   logic       VBlank;
   logic       HSync;
   logic       VSync;
   logic       new_line;
   logic       new_frame;

   int checks   = 0;
   int failures = 0;

   video_timing #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
      .V_ACTIVE(VA), .NTSC_LINES(NL), .PAL_LINES(PL), .VS_START_N(VSN),
      .VS_START_P(VSP), .VS_LEN(VSL)
   ) dut (
      .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
      .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
      .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
      .new_line(new_line), .new_frame(new_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
      end
   endtask

   // Model state: pixel index within the frame, from which position and strobes are derived.
   exp_t q[$];
   exp_t held, want, got, e;
   int   cyc = 0;
   int   m_div, m_t, p_len, f_len, ln, hh;
   logic m_sd, m_pal, m_ce;
   logic in_rst = 1'b1, in_pal = 1'b0, in_sd = 1'b0;
   int   last_ref = 0, last_period = 0, vs_cnt = 0, last_vs = 0, nf_count = 0;

   always @(negedge clk) begin
      cyc++;
      got = {hcount, vcount, HBlank, VBlank, HSync, VSync, new_line, new_frame};
      if (reset || in_rst) begin
         m_div = 0; m_t = 0; m_ce = 1'b0;
         m_sd = in_sd; m_pal = in_pal;
         q.delete();
         held = '0; last_ref = cyc; vs_cnt = 0;
         chk("reset_zero", {7'd0, ce_pix, got}, 32'd0);
      end else begin
         p_len = m_sd ? CD / 2 : CD;
         if (m_div == p_len - 1) begin
            m_div = 0; m_ce = 1'b1; m_t++;
            f_len = HT * (m_sd ? 2 : 1) * (m_pal ? PL : NL);
            e.nf = 1'b0;
            if (m_t == f_len) begin
               m_t = 0; e.nf = 1'b1; m_sd = in_sd; m_pal = in_pal;
            end
            hh   = m_t % HT;
            ln   = m_t / HT;
            if (m_sd) ln = ln / 2;
            e.h  = 9'(hh);
            e.v  = 9'(ln);
            e.hb = (hh >= HA);
            e.vb = (ln >= VA);
            e.hs = (hh >= HSS) && (hh < HSE);
            e.vs = (ln >= (m_pal ? VSP : VSN)) && (ln < (m_pal ? VSP : VSN) + VSL);
            e.nl = (hh == 0);
            q.push_back(e);
         end else begin
            m_div++; m_ce = 1'b0;
         end
         chk("ce_pix", {31'd0, ce_pix}, {31'd0, m_ce});
         want = held;
         if (ce_pix === 1'b1) begin
            if (q.size() == 0) begin
               failures++; checks++;
               $display("FAIL scoreboard_empty: got ce_pix 1 required no pixel at %0t", $time);
            end else begin
               want = q.pop_front();
               held = want; held.nl = 1'b0; held.nf = 1'b0;
            end
         end
         chk("outputs", {8'd0, got}, {8'd0, want});
         if (new_frame === 1'b1) begin
            last_period = cyc - last_ref; last_ref = cyc;
            last_vs = vs_cnt; vs_cnt = 0; nf_count++;
         end else if (new_line === 1'b1 && VSync === 1'b1) begin
            vs_cnt++;
         end
      end
      in_rst = reset; in_pal = pal; in_sd = scandouble;
   end

   task automatic do_reset(input logic p, input logic s);
      @(posedge clk); #2;
      reset = 1'b1; pal = p; scandouble = s;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {7'd0, ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync,
                            new_line, new_frame}, 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic drive(input logic p, input logic s);
      @(posedge clk); #2;
      pal = p; scandouble = s;
   endtask

   // Returns the number of falling edges up to and including the next ce_pix.
   task automatic wait_ce(output int n);
      n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         n++;
         if (ce_pix === 1'b1) return;
      end
      checks++; failures++;
      $display("FAIL ce_timeout: got no ce_pix required one within 50 clks");
   endtask

   task automatic wait_nf();
      int start;
      start = nf_count;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk); #1;
         if (nf_count != start) return;
      end
      checks++; failures++;
      $display("FAIL nf_timeout: got no new_frame required one within 5000 clks");
   endtask

   task automatic wait_pos(input int target);
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk); #1;
         if (m_t >= target) return;
      end
      checks++; failures++;
      $display("FAIL pos_timeout: got model index %0d required %0d", m_t, target);
   endtask

   initial begin
      vec_t vecs[4];
      int   n;
      vecs[0] = '{1'b0, 1'b0, CD,     HT * NL * CD, VSL};
      vecs[1] = '{1'b0, 1'b1, CD / 2, HT * NL * CD, 2 * VSL};
      vecs[2] = '{1'b1, 1'b0, CD,     HT * PL * CD, VSL};
      vecs[3] = '{1'b1, 1'b1, CD / 2, HT * PL * CD, 2 * VSL};
      reset = 1'b1; pal = 1'b0; scandouble = 1'b0;

      for (int i = 0; i < 4; i++) begin
         do_reset(vecs[i].pal, vecs[i].sd);
         release_reset();
         wait_ce(n);
         chk("first_ce", n, vecs[i].gap);
         wait_ce(n);
         chk("ce_period", n, vecs[i].gap);
         wait_nf();
         chk("frame_clks", last_period, vecs[i].frame);
         chk("vsync_lines", last_vs, vecs[i].vsl);
      end

      // pal raised mid-frame: the running frame stays NTSC
      do_reset(1'b0, 1'b0);
      release_reset();
      wait_pos(5 * HT);
      drive(1'b1, 1'b0);
      wait_nf();
      chk("pal_hold_period", last_period, HT * NL * CD);
      wait_nf();
      chk("pal_period", last_period, HT * PL * CD);
      chk("pal_vsync_lines", last_vs, VSL);

      // scandouble raised mid-frame, then dropped mid-frame
      do_reset(1'b0, 1'b0);
      release_reset();
      wait_pos(5 * HT);
      drive(1'b0, 1'b1);
      wait_ce(n);
      wait_ce(n);
      chk("sd_mid_gap", n, CD);
      wait_nf();
      chk("sd_hold_period", last_period, HT * NL * CD);
      wait_ce(n);
      chk("sd_new_gap", n, CD / 2);
      wait_nf();
      chk("sd_period", last_period, HT * NL * CD);
      chk("sd_vsync_lines", last_vs, 2 * VSL);
      wait_pos(3 * HT);
      drive(1'b0, 1'b0);
      wait_ce(n);
      wait_ce(n);
      chk("sd_off_hold_gap", n, CD / 2);

      // one-clock reset inside the HSync/HBlank region of line 7
      do_reset(1'b0, 1'b0);
      release_reset();
      wait_pos(7 * HT + HSS + 1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("async_clear", {7'd0, ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync,
                          new_line, new_frame}, 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk); #1;
      wait_nf();
      chk("post_reset_period", last_period, HT * NL * CD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no completion required finish before 5 ms");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator that sits directly upstream of the mycore pixel/colour stage.
- Produces the pixel clock enable, the beam position (hcount/vcount) and blank/sync strobes for NTSC or PAL, with optional scan-doubling.
- The pixel stage uses hcount/vcount to address and draw pixels, and forwards the blank/sync strobes to the emu top level.

Parameters:
CLK_DIV, 4, clk cycles per pixel in single-scan mode (even, ≥2)
H_ACTIVE, 320, visible pixels per line
H_TOTAL, 384, pixels per line incl. blanking
HS_START, 336, first hcount with HSync high
HS_END, 368, first hcount after HSync (exclusive)
V_ACTIVE, 240, visible source lines
NTSC_LINES, 262, source lines per frame, pal=0
PAL_LINES, 312, source lines per frame, pal=1
VS_START_N, 244, first VSync line, NTSC
VS_START_P, 270, first VSync line, PAL
VS_LEN, 3, VSync length in source lines

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pal  in  1  0=NTSC, 1=PAL; sampled at frame boundary
scandouble  in  1  1=31kHz doubled output; sampled at frame boundary
ce_pix  out  1  one-clk pixel enable
hcount  out  9  pixel position in line, 0..H_TOTAL-1
vcount  out  9  source line, 0..lines-1
HBlank  out  1  hcount >= H_ACTIVE
VBlank  out  1  vcount >= V_ACTIVE
HSync  out  1  HS_START <= hcount < HS_END
VSync  out  1  VS_START <= vcount < VS_START+VS_LEN
new_line  out  1  one-clk pulse when hcount wraps to 0
new_frame  out  1  one-clk pulse when hcount and vcount both wrap to 0

Behaviour:
- Reset (async assert, sync release): all outputs 0; divider 0; line-repeat bit 0.
  - pal_l and sd_l load from their pins at reset release.
- Divider:
  - Period P = CLK_DIV when sd_l=0, CLK_DIV/2 when sd_l=1.
  - The div counter increments every clk. When div == P-1: div<=0 and ce_pix<=1 on the same edge. Otherwise ce_pix<=0.
  - First ce_pix is high after the P-th clk edge following reset release.
- Counters advance only on edges where the internal ce (div==P-1) is true.
  - hcount: +1; at H_TOTAL-1 wraps to 0.
  - Line end (hcount wraps):
    - sd_l=0: vcount +1.
    - sd_l=1: rep toggles; vcount advances only when rep was 1. Each source line is therefore emitted twice.
  - vcount wraps to 0 after (pal_l ? PAL_LINES : NTSC_LINES)-1, on the final repeat when doubled.
- Output registration:
  - HBlank/VBlank/HSync/VSync are registered from the next counter values. Every flag is therefore consistent with the hcount/vcount presented in the same cycle (zero relative latency).
  - All position and strobe outputs hold between ce cycles.
- new_line, new_frame:
  - Asserted coincident with ce_pix on the edge where the counters wrap.
  - new_frame implies new_line. Each pulse lasts exactly one clk.
- Frame boundary (new_frame edge): pal_l<=pal and sd_l<=scandouble; rep<=0.
  - Changes of pal or scandouble mid-frame have no effect until the next frame.
  - The new P takes effect from the following divider cycle.
- VSync start line: VS_START_N when pal_l=0, VS_START_P when pal_l=1.
- Sync polarity: active-high.
- Width rule: counters are 9 bits; parameter values must fit in 9 bits. No other range checking.
- Reset mid-frame: counters return to 0 immediately (async).
  - The first frame after release is full length and starts at hcount=0, vcount=0 with no new_frame pulse.
- Frame length in clk cycles:
  - Single-scan: H_TOTAL*lines*CLK_DIV.
  - Doubled: H_TOTAL*2*lines*CLK_DIV/2. The frame period is identical in both modes.

Test Plan:
- Reset/ce:
  - Stimulus: hold reset, then release with scandouble=0.
  - Required: all outputs 0 during reset; ce_pix first high on edge 4 after release, then every 4 clks.
  - Stimulus: scandouble=1 at release.
  - Required: ce_pix every 2 clks.
- Single line:
  - Required: HBlank rises with hcount=320, HSync high exactly for hcount 336..367 (32 ce).
  - Required: new_line coincides with hcount 383→0; vcount increments by 1.
- NTSC frame, pal=0:
  - Required: new_frame period = 384*262*4 = 402432 clks.
  - Required: VBlank high for vcount 240..261; VSync high for vcount 244..246.
- PAL switch:
  - Stimulus: raise pal at vcount=100.
  - Required: current frame still wraps after vcount 261; next frame counts to 311 with VSync on 270..272.
  - Required: new_frame period = 479232 clks.
- Scandouble:
  - Stimulus: scandouble=1 from reset.
  - Required: each vcount value spans 2 new_line pulses; VSync asserted for 6 output lines; frame period still 402432 clks.
  - Stimulus: toggle scandouble mid-frame.
  - Required: no change until new_frame.
- Reset mid-operation:
  - Stimulus: assert reset at hcount=200, vcount=150 for 1 clk.
  - Required: hcount, vcount and all strobes 0 asynchronously; counting resumes from 0,0 after release with no spurious new_frame.
